// File: rtl/spi_ram_arbiter_pkg.sv
// spi_ram_arbiter_pkg
//   Shared types and constants for the SPI RAM arbiter:
//   FSM state enum, granted-port id enum, SPI RAM command bytes.
package spi_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_ram_arbiter_shifter.sv
// spi_shifter
//   Frame shift register, bit counter and bit phase for one SPI RAM transaction.
//   A frame is {cmd[7:0], addr, data}, sent MSB first, two clk cycles per bit.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   load        capture cmd/addr/wdata and restart counter and phase
//   en          advance the shifter (FSM is in SHIFT)
//   cmd, addr, wdata   frame contents captured on load
//   miso        serial input, sampled at the end of phase 1
//   mosi        current outgoing bit (frame MSB)
//   phase       0 = drive bit, spi_clk low; 1 = spi_clk high, sample
//   last        final phase-1 cycle of the frame
//   rx_word     received data word including the bit sampled this cycle
module spi_shifter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [7:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              miso,
  output logic              mosi,
  output logic              phase,
  output logic              last,
  output logic [DATA_W-1:0] rx_word
);

  localparam int unsigned FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load) begin
      sreg_d  = {cmd, addr, wdata};
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        // Received bits fill from the LSB; the read word ends up in the low DATA_W bits.
        sreg_d  = {sreg_q[FRAME_W-2:0], miso};
        // Saturate at the terminal count instead of wrapping.
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign mosi    = sreg_q[FRAME_W-1];
  assign phase   = phase_q;
  assign last    = en && phase_q && (cnt_q == CNT_LAST);
  assign rx_word = {sreg_q[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Arbitrates an instruction-fetch read port and a load/store port onto a
//   single mode-0 SPI RAM. FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
//   Default arbitration is fixed priority (data over fetch). Defining the
//   macro SPI_ARB_RR_EN selects round-robin arbitration on collisions.
// Ports:
//   clk, rst_n                          system clock, async active-low reset
//   fetch_req/addr -> fetch_ack/rdata   fetch read port (level req, 1-cycle ack)
//   data_req/we/addr/wdata -> data_ack/rdata   load/store port
//   spi_select (active low), spi_clk, spi_mosi, spi_miso   SPI RAM pins
//   busy                                high whenever the FSM is not IDLE
module spi_ram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              spi_select,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy
);

  import spi_ram_arbiter_pkg::*;

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              grant;
  logic              pick_data;
  logic [7:0]        ld_cmd;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              sh_mosi;
  logic              sh_phase;
  logic              sh_last;
  logic [DATA_W-1:0] sh_rx_word;

`ifdef SPI_ARB_RR_EN
  // prio_q names the port that wins the next collision.
  port_e prio_q, prio_d;

  assign pick_data = data_req && (!fetch_req || (prio_q == PORT_DATA));

  always_comb begin
    prio_d = prio_q;
    if (grant) begin
      prio_d = pick_data ? PORT_FETCH : PORT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PORT_FETCH;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign pick_data = data_req;
`endif

  // Frame contents are captured by the shifter at grant, isolating the
  // transaction from later port changes.
  assign ld_cmd   = (pick_data && data_we) ? CMD_WRITE : CMD_READ;
  assign ld_addr  = pick_data ? data_addr : fetch_addr;
  assign ld_wdata = (pick_data && data_we) ? data_wdata : '0;

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    we_d          = we_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    grant         = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          grant   = 1'b1;
          state_d = SETUP;
          port_d  = pick_data ? PORT_DATA : PORT_FETCH;
          we_d    = pick_data && data_we;
        end
      end
      SETUP: state_d = SHIFT;
      SHIFT: begin
        if (sh_last) begin
          state_d = DONE;
          if (!we_q) begin
            if (port_q == PORT_DATA) begin
              data_rdata_d = sh_rx_word;
            end else begin
              fetch_rdata_d = sh_rx_word;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      port_q        <= PORT_FETCH;
      we_q          <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      we_q          <= we_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  spi_shifter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant),
    .en      (state_q == SHIFT),
    .cmd     (ld_cmd),
    .addr    (ld_addr),
    .wdata   (ld_wdata),
    .miso    (spi_miso),
    .mosi    (sh_mosi),
    .phase   (sh_phase),
    .last    (sh_last),
    .rx_word (sh_rx_word)
  );

  // Pin outputs decode directly from state so reset forces them immediately.
  assign spi_select  = !((state_q == SETUP) || (state_q == SHIFT));
  assign spi_clk     = (state_q == SHIFT) && sh_phase;
  assign spi_mosi    = (state_q == SHIFT) && sh_mosi;
  assign busy        = (state_q != IDLE);
  assign fetch_ack   = (state_q == DONE) && (port_q == PORT_FETCH);
  assign data_ack    = (state_q == DONE) && (port_q == PORT_DATA);
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_ack;
  logic [15:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] data_addr = '0;
  logic [15:0] data_wdata = '0;
  logic        data_ack;
  logic [15:0] data_rdata;
  logic        spi_select;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [39:0] frame_q[$];

  // SPI RAM model: captures MOSI on spi_clk rise, drives MISO while spi_clk is low.
  logic [15:0] mem [0:65535];
  logic [39:0] sh = '0;
  int          bit_n = 0;
  logic [7:0]  ram_cmd = '0;
  logic [15:0] ram_addr = '0;

  always @(negedge spi_select) begin
    bit_n = 0;
    sh = '0;
  end

  always @(posedge spi_clk) begin
    if (!spi_select) begin
      sh = {sh[38:0], spi_mosi};
      bit_n++;
      if (bit_n == 8) ram_cmd = sh[7:0];
      if (bit_n == 24) ram_addr = sh[15:0];
    end
  end

  always @(posedge spi_select) begin
    if (bit_n == 40) begin
      frame_q.push_back(sh);
      if (sh[39:32] == 8'h02) mem[sh[31:16]] = sh[15:0];
    end
    bit_n = 0;
  end

  always @(negedge clk) begin
    if (spi_select === 1'b0 && spi_clk === 1'b0) begin
      if (ram_cmd == 8'h03 && bit_n >= 24 && bit_n < 40)
        spi_miso = mem[ram_addr][39 - bit_n];
      else
        spi_miso = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_ack(input int max_cyc, output bit got_f, output bit got_d, output int cyc);
    got_f = 1'b0;
    got_d = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && !got_f && !got_d) begin
      @(negedge clk);
      cyc++;
      got_f = fetch_ack;
      got_d = data_ack;
    end
  endtask

  task automatic take(output txn_t e, output logic [39:0] fr, output bit ok);
    ok = (exp_q.size() > 0) && (frame_q.size() > 0);
    e = '{default: 0};
    fr = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (frame_q.size() > 0) fr = frame_q.pop_front();
  endtask

  function automatic logic [39:0] frame_of(input txn_t e);
    return {e.we ? 8'h02 : 8'h03, e.addr, e.we ? e.wdata : 16'h0000};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({spi_select, spi_clk, spi_mosi, busy, fetch_ack, data_ack} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_pins: got %b want 100000",
               {spi_select, spi_clk, spi_mosi, busy, fetch_ack, data_ack});
    end
    checks++;
    if (fetch_rdata !== 16'h0 || data_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0000/0000", fetch_rdata, data_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spi_select !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b sel=%b want 0/1", busy, spi_select);
    end
  endtask

  task automatic test_fetch_read();
    bit gf, gd, ok;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    mem[16'h1234] = 16'hBEEF;
    exp_q.push_back('{0, 0, 16'h1234, 16'h0, 16'hBEEF});
    fetch_addr = 16'h1234;
    fetch_req = 1'b1;
    wait_ack(200, gf, gd, cyc);
    fetch_req = 1'b0;
    checks++;
    if (!gf || gd) begin
      errors++;
      $display("FAIL fetch_ack_port: fetch_ack=%b data_ack=%b want 1/0", gf, gd);
    end
    checks++;
    if (cyc != 82) begin
      errors++;
      $display("FAIL fetch_latency: got %0d want 82", cyc);
    end
    take(e, fr, ok);
    checks++;
    if (!ok || fr !== frame_of(e)) begin
      errors++;
      $display("FAIL fetch_mosi_frame: got %h want %h", fr, frame_of(e));
    end
    checks++;
    if (fetch_rdata !== e.rdata) begin
      errors++;
      $display("FAIL fetch_rdata: got %h want %h", fetch_rdata, e.rdata);
    end
    @(negedge clk);
    checks++;
    if (fetch_ack !== 1'b0 || busy !== 1'b0 || fetch_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_after_ack: ack=%b busy=%b rdata=%h want 0/0/beef",
               fetch_ack, busy, fetch_rdata);
    end
  endtask

  task automatic test_data_write();
    bit gf, gd, ok;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    exp_q.push_back('{1, 1, 16'h00FF, 16'hA55A, 16'h0});
    data_we = 1'b1;
    data_addr = 16'h00FF;
    data_wdata = 16'hA55A;
    data_req = 1'b1;
    repeat (3) @(negedge clk);
    data_wdata = 16'h0000;
    wait_ack(200, gf, gd, cyc);
    data_req = 1'b0;
    data_we = 1'b0;
    checks++;
    if (!gd || gf || cyc + 3 != 82) begin
      errors++;
      $display("FAIL write_ack: data_ack=%b fetch_ack=%b cycles=%0d want 1/0/82", gd, gf, cyc + 3);
    end
    take(e, fr, ok);
    checks++;
    if (!ok || fr !== frame_of(e)) begin
      errors++;
      $display("FAIL write_mosi_frame: got %h want %h", fr, frame_of(e));
    end
    checks++;
    if (mem[16'h00FF] !== 16'hA55A) begin
      errors++;
      $display("FAIL write_ram: got %h want a55a", mem[16'h00FF]);
    end
    checks++;
    if (data_rdata !== 16'h0) begin
      errors++;
      $display("FAIL write_rdata_hold: got %h want 0000", data_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_data_read();
    bit gf, gd, ok;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    exp_q.push_back('{1, 0, 16'h00FF, 16'h0, 16'hA55A});
    data_we = 1'b0;
    data_addr = 16'h00FF;
    data_req = 1'b1;
    wait_ack(200, gf, gd, cyc);
    data_req = 1'b0;
    take(e, fr, ok);
    checks++;
    if (!gd || cyc != 82 || !ok || fr !== frame_of(e)) begin
      errors++;
      $display("FAIL read_txn: ack=%b cycles=%0d frame=%h want 1/82/%h", gd, cyc, fr, frame_of(e));
    end
    checks++;
    if (data_rdata !== e.rdata) begin
      errors++;
      $display("FAIL read_rdata: got %h want %h", data_rdata, e.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    bit gf, gd, ok, last;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    bit seq[$];
`ifdef SPI_ARB_RR_EN
    seq = '{1'b0, 1'b1, 1'b0};
`else
    seq = '{1'b1, 1'b0};
`endif
    foreach (seq[i])
      exp_q.push_back('{seq[i], 0, seq[i] ? 16'h0200 : 16'h0100, 16'h0,
                        seq[i] ? mem[16'h0200] : mem[16'h0100]});
    fetch_addr = 16'h0100;
    data_addr = 16'h0200;
    data_we = 1'b0;
    fetch_req = 1'b1;
    data_req = 1'b1;
    for (int unsigned i = 0; i < seq.size(); i++) begin
      wait_ack(200, gf, gd, cyc);
      last = 1'b1;
      for (int unsigned j = i + 1; j < seq.size(); j++)
        if (seq[j] == seq[i]) last = 1'b0;
      if (last) begin
        if (seq[i]) data_req = 1'b0;
        else fetch_req = 1'b0;
      end
      checks++;
      if (!(gf || gd) || gd !== seq[i]) begin
        errors++;
        $display("FAIL collision_order[%0d]: fetch_ack=%b data_ack=%b want data=%b", i, gf, gd, seq[i]);
      end
      take(e, fr, ok);
      checks++;
      if (!ok || fr !== frame_of(e) || (gd ? data_rdata : fetch_rdata) !== e.rdata) begin
        errors++;
        $display("FAIL collision_txn[%0d]: frame=%h rdata=%h want %h/%h", i, fr,
                 gd ? data_rdata : fetch_rdata, frame_of(e), e.rdata);
      end
    end
    fetch_req = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit gf, gd, ok;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    for (int unsigned i = 0; i < 3; i++)
      exp_q.push_back('{0, 0, 16'h0300, 16'h0, mem[16'h0300]});
    fetch_addr = 16'h0300;
    fetch_req = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      wait_ack(200, gf, gd, cyc);
      if (i == 2) fetch_req = 1'b0;
      checks++;
      if (!gf || cyc != ((i == 0) ? 82 : 81)) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: ack=%b cycles=%0d want 1/%0d", i, gf, cyc, (i == 0) ? 82 : 81);
      end
      take(e, fr, ok);
      checks++;
      if (!ok || fr !== frame_of(e) || fetch_rdata !== e.rdata) begin
        errors++;
        $display("FAIL b2b_txn[%0d]: frame=%h rdata=%h want %h/%h", i, fr, fetch_rdata, frame_of(e), e.rdata);
      end
      @(negedge clk);
      checks++;
      if (fetch_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_gap[%0d]: ack=%b busy=%b want 0/0", i, fetch_ack, busy);
      end
      if (i < 2) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || spi_select !== 1'b0) begin
          errors++;
          $display("FAIL b2b_setup[%0d]: busy=%b sel=%b want 1/0", i, busy, spi_select);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit gf, gd, ok, acked;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    fetch_addr = 16'h0ABC;
    fetch_req = 1'b1;
    repeat (41) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || spi_select !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre_busy: busy=%b sel=%b want 1/0", busy, spi_select);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_select, spi_clk, spi_mosi, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_same_cycle: got %b want 1000", {spi_select, spi_clk, spi_mosi, busy});
    end
    acked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fetch_ack || data_ack) acked = 1'b1;
    end
    checks++;
    if (acked || frame_q.size() != 0 || fetch_rdata !== 16'h0) begin
      errors++;
      $display("FAIL abort_no_ack: ack=%b frames=%0d rdata=%h want 0/0/0000", acked, frame_q.size(), fetch_rdata);
    end
    exp_q.push_back('{0, 0, 16'h0ABC, 16'h0, mem[16'h0ABC]});
    rst_n = 1'b1;
    wait_ack(200, gf, gd, cyc);
    fetch_req = 1'b0;
    take(e, fr, ok);
    checks++;
    if (!gf || cyc != 82 || !ok || fr !== frame_of(e) || fetch_rdata !== e.rdata) begin
      errors++;
      $display("FAIL abort_retry: ack=%b cycles=%0d frame=%h rdata=%h want 1/82/%h/%h",
               gf, cyc, fr, fetch_rdata, frame_of(e), e.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_stable();
    bit gf, gd, ok;
    int cyc;
    txn_t e;
    logic [39:0] fr;
    exp_q.push_back('{0, 0, 16'h0001, 16'h0, mem[16'h0001]});
    fetch_addr = 16'h0001;
    fetch_req = 1'b1;
    repeat (20) @(negedge clk);
    fetch_addr = 16'hFFFF;
    wait_ack(200, gf, gd, cyc);
    fetch_req = 1'b0;
    take(e, fr, ok);
    checks++;
    if (!gf || cyc + 20 != 82 || !ok || fr !== frame_of(e)) begin
      errors++;
      $display("FAIL addr_stable_frame: ack=%b cycles=%0d frame=%h want 1/82/%h", gf, cyc + 20, fr, frame_of(e));
    end
    checks++;
    if (fetch_rdata !== e.rdata) begin
      errors++;
      $display("FAIL addr_stable_rdata: got %h want %h", fetch_rdata, e.rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C96;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_data_read();
    test_collision();
    test_back_to_back();
    test_reset_abort();
    test_addr_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, is the SPI RAM address width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter DATA_W, default 16, is the transfer word width in bits; it SHALL be a multiple of 8.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fetch_req  input  1  instruction-fetch read request, level, held until fetch_ack.
REQ-006 fetch_addr  input  ADDR_W  fetch address, stable while fetch_req is high.
REQ-007 fetch_ack  output  1  one-cycle pulse; fetch_rdata is valid in that cycle.
REQ-008 fetch_rdata  output  DATA_W  fetch read data, held until the next fetch completes.
REQ-009 data_req  input  1  load/store request, level, held until data_ack.
REQ-010 data_we  input  1  1 = write, 0 = read; stable while data_req is high.
REQ-011 data_addr  input  ADDR_W  load/store address.
REQ-012 data_wdata  input  DATA_W  store data.
REQ-013 data_ack  output  1  one-cycle completion pulse.
REQ-014 data_rdata  output  DATA_W  load data, valid in the data_ack cycle and held until the next data read completes.
REQ-015 spi_select  output  1  RAM chip select, active low.
REQ-016 spi_clk  output  1  SPI clock, mode 0, idles low.
REQ-017 spi_mosi  output  1  serial data to RAM, MSB first.
REQ-018 spi_miso  input  1  serial data from RAM.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, SHIFT and DONE.
REQ-021 In IDLE with at least one request pending, the arbiter SHALL grant one port, latch its op, addr and wdata, and move to SETUP.
REQ-022 Default arbitration SHALL be fixed priority: data over fetch when both requests are high in the same cycle.
REQ-023 SETUP SHALL last 1 cycle with spi_select driven low and spi_clk low; the FSM then enters SHIFT.
REQ-024 SHIFT SHALL send the command byte (0x03 for read, 0x02 for write), then the address, then DATA_W data bits, all MSB first.
REQ-025 Each bit SHALL take 2 cycles: phase 0 drives spi_mosi with spi_clk low, phase 1 raises spi_clk and samples spi_miso.
REQ-026 SHIFT SHALL last 2*(8+ADDR_W+DATA_W) cycles, which is 80 at default parameters.
REQ-027 During the read data phase spi_mosi SHALL be 0; during write, spi_miso SHALL be ignored.
REQ-028 DONE SHALL last 1 cycle: spi_select high, spi_clk low, the granted port's ack pulses, and read data is updated; the FSM then returns to IDLE.
REQ-029 Latency from the grant cycle to ack SHALL be 82 cycles at default parameters.
REQ-030 A request still high in the cycle after ack SHALL be treated as a new request.
REQ-031 A request arriving while busy SHALL wait and be arbitrated in the next IDLE cycle.
REQ-032 The bit counter SHALL stop at its terminal count, never wrap within a transaction, and reload on every grant.
REQ-033 Changes to port inputs after the grant SHALL NOT affect the transaction in flight.

Reset
REQ-034 On rst_n low, the block SHALL asynchronously enter IDLE, including mid-transaction, with no ack for the aborted request.
REQ-035 Reset values SHALL be: spi_select=1, spi_clk=0, spi_mosi=0, busy=0, both acks=0, both rdata=0, round-robin pointer=fetch.

Configuration
REQ-036 Macro SPI_ARB_RR_EN, when defined, SHALL select round-robin arbitration: on a simultaneous request, the port not served most recently wins.
REQ-037 Without SPI_ARB_RR_EN, arbitration SHALL be fixed priority per REQ-022, and no pointer register SHALL exist.

Structure
REQ-038 A shared package SHALL hold: the state enum, the command constants CMD_READ=8'h03 and CMD_WRITE=8'h02, and the port-id enum (PORT_FETCH, PORT_DATA).
REQ-039 One sub-module, spi_shifter, SHALL hold the shift register, bit counter and phase; the arbitration and FSM logic SHALL stay in spi_ram_arbiter.

Verification
REQ-040 fetch_req with addr 0x1234 and RAM model returning 0xBEEF -> MOSI bits 0x03,0x12,0x34,then 16 zeros; fetch_ack at grant+82 cycles; fetch_rdata=0xBEEF.
REQ-041 data write, addr 0x00FF, wdata 0xA55A -> MOSI bits 0x02,0x00,0xFF,0xA5,0x5A; data_ack pulse; RAM model holds 0xA55A at 0x00FF.
REQ-042 fetch_req and data_req both rising in the same cycle -> data served first, then fetch; with SPI_ARB_RR_EN, fetch first, and a repeat of the collision serves data first.
REQ-043 rst_n low at cycle 40 of SHIFT -> same-cycle spi_select=1, spi_clk=0, busy=0; no ack; the request is re-served from a fresh SETUP after reset.
REQ-044 fetch_req held high continuously -> back-to-back transactions, one IDLE cycle between DONE and the next SETUP, one ack per transaction.
REQ-045 fetch_addr changed to 0xFFFF mid-SHIFT after the grant of 0x0001 -> address bits on MOSI remain 0x0001.
